// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the round-robin arbiter slice.
//   ARB_FIXED / ARB_RR  - priority mode select for rr_pick
//   idx_w()             - width of a requester index (ptr, gnt_idx)
//   cnt_w()             - width of the hold counter, minimum 1 bit
//   onehot_to_idx()     - binary index of the set bit in a one-hot vector (up to 64 bits)
package arb_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

  // Returns 0 for an all-zero vector, so gnt_idx falls to 0 with no grant.
  function automatic int onehot_to_idx(input logic [63:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner selection.
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    round-robin start index (highest priority)
//   mode   in  1        ARB_RR: first request at/after ptr, wrapping; ARB_FIXED: highest index
//   winner out IDX_W    selected requester index (0 when nothing requests)
//   found  out 1        at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] masked;

  // The doubled vector turns the wrapping search into a linear one: the lower
  // copy is masked below ptr, the upper copy supplies the wrapped-around bits.
  always_comb begin
    dbl    = {req, req};
    mask   = '0;
    winner = '0;
    found  = |req;
    for (int j = 0; j < 2 * NUM_REQ; j++) begin
      mask[j] = (j >= int'(ptr));
    end
    masked = dbl & mask;
    if (mode == ARB_RR) begin
      // Descending scan so the lowest set position is the last one written.
      for (int j = 2 * NUM_REQ - 1; j >= 0; j--) begin
        if (masked[j]) winner = (j >= NUM_REQ) ? IDX_W'(j - NUM_REQ) : IDX_W'(j);
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) winner = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way request arbiter with registered one-hot grant.
//   clock     in  1        system clock, rising edge
//   reset     in  1        asynchronous, active-high reset
//   req       in  NUM_REQ  request vector
//   en        in  1        arbitration enable
//   hold      in  1        keep current grant while holder still requests (bounded by MAX_HOLD)
//   gnt       out NUM_REQ  registered one-hot grant
//   gnt_idx   out log2(N)  binary index of granted requester, 0 when no grant
//   gnt_valid out 1        registered |gnt
//   req_up    out 1        combinational |req for cascading, not gated by en
// NUM_REQ is limited to 64 by onehot_to_idx.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter bit RR_EN    = 1'b1,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  input  logic                       hold,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_valid,
  output logic                       req_up
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [IW-1:0]      winner;
  logic               found;
  logic               hold_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .mode   (RR_EN ? ARB_RR : ARB_FIXED),
    .winner (winner),
    .found  (found)
  );

  assign hold_ok = hold && gnt_valid_q && req[gnt_idx_q] &&
                   ((MAX_HOLD == 0) || (cnt_q < HOLD_LIM));

  always_comb begin
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    ptr_d       = ptr_q;
    cnt_d       = '0;
    if (!en) begin
      gnt_d = '0;
    end else if (hold_ok) begin
      gnt_d       = gnt_q;
      gnt_valid_d = 1'b1;
      cnt_d       = (cnt_q != {CW{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end else if (found) begin
      gnt_d[winner] = 1'b1;
      gnt_valid_d   = 1'b1;
      cnt_d         = CW'(1);
      if (!RR_EN)                 ptr_d = '0;
      else if (winner == LAST_IDX) ptr_d = '0;
      else                        ptr_d = winner + 1'b1;
    end
    // Index derived from the grant itself so the two can never disagree.
    gnt_idx_d = IW'(onehot_to_idx(64'(gnt_d)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign req_up    = |req;

endmodule
